simd_mask_reducer: RTL and testbench



---
 rtl/simd_mask_reducer_pkg.sv | 58 +++++
 rtl/simd_mask_popcnt_enc.sv | 41 ++++
 rtl/simd_mask_reducer.sv | 145 ++++++++++++++
 tb/tb_simd_mask_reducer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_mask_reducer_pkg.sv
// Shared definitions for the SIMD comparator and its mask reducer.
package simd_mask_reducer_pkg;

   localparam int unsigned SIMD_WIDTH = 256;
   localparam int unsigned MAX_LANES  = SIMD_WIDTH / 8;
   localparam int unsigned MODE_W     = 3;
   localparam int unsigned CNT_W      = 6;
   localparam int unsigned IDX_W      = 5;
   localparam int unsigned LW_W       = 9;

   localparam logic [MODE_W-1:0] MODE_8   = 3'd0;
   localparam logic [MODE_W-1:0] MODE_16  = 3'd1;
   localparam logic [MODE_W-1:0] MODE_32  = 3'd2;
   localparam logic [MODE_W-1:0] MODE_64  = 3'd3;
   localparam logic [MODE_W-1:0] MODE_128 = 3'd4;
   localparam logic [MODE_W-1:0] MODE_256 = 3'd5;

   // Stage-1 payload: extracted lane MSBs plus the raw mode
   typedef struct packed {
      logic [MAX_LANES-1:0] mask;
      logic [MODE_W-1:0]    mode;
   } s1_entry_t;

   // Stage-2 payload: everything presented on the output port
   typedef struct packed {
      logic [MAX_LANES-1:0] mask;
      logic [CNT_W-1:0]     count;
      logic                 any;
      logic                 all;
      logic [IDX_W-1:0]     first;
      logic [MODE_W-1:0]    mode;
   } red_result_t;

   // Number of lanes for a mode; 5..7 all mean one 256-bit lane
   function automatic logic [CNT_W-1:0] lanes_for_mode(input logic [MODE_W-1:0] mode);
      case (mode)
         MODE_8:   return CNT_W'(32);
         MODE_16:  return CNT_W'(16);
         MODE_32:  return CNT_W'(8);
         MODE_64:  return CNT_W'(4);
         MODE_128: return CNT_W'(2);
         default:  return CNT_W'(1);
      endcase
   endfunction

   // Lane width in bits for a mode
   function automatic logic [LW_W-1:0] lane_width_for_mode(input logic [MODE_W-1:0] mode);
      case (mode)
         MODE_8:   return LW_W'(8);
         MODE_16:  return LW_W'(16);
         MODE_32:  return LW_W'(32);
         MODE_64:  return LW_W'(64);
         MODE_128: return LW_W'(128);
         default:  return LW_W'(256);
      endcase
   endfunction

endpackage

// File: rtl/simd_mask_popcnt_enc.sv
// Combinational popcount, lowest-set-bit encoder and any flag for a lane mask.
module simd_mask_popcnt_enc
   import simd_mask_reducer_pkg::*;
(
   input  logic [MAX_LANES-1:0] mask,
   output logic [CNT_W-1:0]     pop_count_c,
   output logic [IDX_W-1:0]     first_idx_c,
   output logic                 any_c
);

   logic [MAX_LANES-1:0] cnt_shift;
   logic [MAX_LANES-1:0] enc_shift;

   // Popcount by walking the mask LSB-first
   always_comb begin
      pop_count_c = '0;
      cnt_shift   = mask;
      for (int k = 0; k < int'(MAX_LANES); k++) begin
         pop_count_c = pop_count_c + CNT_W'(cnt_shift[0]);
         cnt_shift   = cnt_shift >> 1;
      end
   end

   // Priority encode: walk top-down so the lowest set bit wins; 0 when empty
   always_comb begin
      first_idx_c = '0;
      enc_shift   = mask;
      for (int k = 0; k < int'(MAX_LANES); k++) begin
         if (enc_shift[MAX_LANES-1]) begin
            first_idx_c = IDX_W'(int'(MAX_LANES) - 1 - k);
         end
         enc_shift = enc_shift << 1;
      end
   end

   // Any lane set
   always_comb begin
      any_c = |mask;
   end

endmodule

// File: rtl/simd_mask_reducer.sv
// Two-stage valid/ready pipeline reducing a comparator result to a lane mask and flags.
module simd_mask_reducer
   import simd_mask_reducer_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SIMD_WIDTH-1:0] cmp_in,
   input  logic [MODE_W-1:0]     data_mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [MAX_LANES-1:0]  lane_mask,
   output logic [CNT_W-1:0]      lane_count,
   output logic                  any_set,
   output logic                  all_set,
   output logic [IDX_W-1:0]      first_idx,
   output logic [MODE_W-1:0]     out_mode
);

   logic        s1_valid_q, s1_valid_d;
   s1_entry_t   s1_data_q,  s1_data_d;
   logic        s2_valid_q, s2_valid_d;
   red_result_t s2_data_q,  s2_data_d;

   logic                 s1_free_c;
   logic                 s2_load_c;
   logic [MAX_LANES-1:0] mask_ext_c;
   logic [CNT_W-1:0]     pop_count_c;
   logic [IDX_W-1:0]     first_idx_c;
   logic                 any_c;

   logic [31:0] m8_c;
   logic [15:0] m16_c;
   logic [7:0]  m32_c;
   logic [3:0]  m64_c;
   logic [1:0]  m128_c;
   logic        m256_c;

   // Only lane MSBs are inspected; the remaining comparator bits are don't-care
   logic unused_cmp_bits;
   assign unused_cmp_bits = ^cmp_in;

   // Lane MSB taps for every lane size
   for (genvar g = 0; g < 32; g++) begin : g_m8
      assign m8_c[g] = cmp_in[8*g+7];
   end
   for (genvar g = 0; g < 16; g++) begin : g_m16
      assign m16_c[g] = cmp_in[16*g+15];
   end
   for (genvar g = 0; g < 8; g++) begin : g_m32
      assign m32_c[g] = cmp_in[32*g+31];
   end
   for (genvar g = 0; g < 4; g++) begin : g_m64
      assign m64_c[g] = cmp_in[64*g+63];
   end
   for (genvar g = 0; g < 2; g++) begin : g_m128
      assign m128_c[g] = cmp_in[128*g+127];
   end
   assign m256_c = cmp_in[SIMD_WIDTH-1];

   // Select the tap set for the incoming mode; unused upper lanes stay zero
   always_comb begin
      mask_ext_c = '0;
      case (data_mode)
         MODE_8:   mask_ext_c = m8_c;
         MODE_16:  mask_ext_c = MAX_LANES'(m16_c);
         MODE_32:  mask_ext_c = MAX_LANES'(m32_c);
         MODE_64:  mask_ext_c = MAX_LANES'(m64_c);
         MODE_128: mask_ext_c = MAX_LANES'(m128_c);
         default:  mask_ext_c = MAX_LANES'(m256_c);
      endcase
   end

   // Stall control: in_ready depends only on registered state and out_ready
   always_comb begin
      s2_load_c = s1_valid_q && (!s2_valid_q || out_ready);
      s1_free_c = !s1_valid_q || s2_load_c;
      in_ready  = !s1_valid_q || !s2_valid_q || out_ready;
   end

   // Stage 1 next state: capture on accept, otherwise hold or empty
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      if (s1_free_c) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_data_d.mask = mask_ext_c;
            s1_data_d.mode = data_mode;
         end
      end
   end

   simd_mask_popcnt_enc u_popcnt_enc (
      .mask        (s1_data_q.mask),
      .pop_count_c (pop_count_c),
      .first_idx_c (first_idx_c),
      .any_c       (any_c)
   );

   // Stage 2 next state: reduce stage-1 entry when the output slot frees up
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_data_d  = s2_data_q;
      if (!s2_valid_q || out_ready) begin
         s2_valid_d = s1_valid_q;
      end
      if (s2_load_c) begin
         s2_data_d.mask  = s1_data_q.mask;
         s2_data_d.count = pop_count_c;
         s2_data_d.any   = any_c;
         s2_data_d.all   = (pop_count_c == lanes_for_mode(s1_data_q.mode));
         s2_data_d.first = first_idx_c;
         s2_data_d.mode  = s1_data_q.mode;
      end
   end

   // Pipeline registers; reset empties both stages and clears all data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
      end
   end

   // Output port mapping straight from stage-2 flops
   always_comb begin
      out_valid  = s2_valid_q;
      lane_mask  = s2_data_q.mask;
      lane_count = s2_data_q.count;
      any_set    = s2_data_q.any;
      all_set    = s2_data_q.all;
      first_idx  = s2_data_q.first;
      out_mode   = s2_data_q.mode;
   end

endmodule

// File: tb/tb_simd_mask_reducer.sv
// Directed plus randomised scoreboard bench for simd_mask_reducer.
module tb_simd_mask_reducer;

   typedef struct packed {
      logic [31:0] mask;
      logic [5:0]  cnt;
      logic        any;
      logic        all;
      logic [4:0]  first;
      logic [2:0]  mode;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [255:0] cmp_in;
   logic [2:0]   data_mode;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  lane_mask;
   logic [5:0]   lane_count;
   logic         any_set;
   logic         all_set;
   logic [4:0]   first_idx;
   logic [2:0]   out_mode;

   exp_t sb[$];
   exp_t held;
   bit   held_valid = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;
   int   accepted    = 0;
   int   popped      = 0;

   always #5 clk = ~clk;

   simd_mask_reducer dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .cmp_in     (cmp_in),
      .data_mode  (data_mode),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .lane_mask  (lane_mask),
      .lane_count (lane_count),
      .any_set    (any_set),
      .all_set    (all_set),
      .first_idx  (first_idx),
      .out_mode   (out_mode)
   );

   // Reference: lane count from mode, MSB of each lane, then reductions
   function automatic exp_t model(input logic [255:0] c, input logic [2:0] m);
      exp_t         e;
      int           nl;
      int           lw;
      int           n;
      bit           found;
      logic [255:0] t;
      e     = '0;
      nl    = (m >= 3'd5) ? 1 : (32 >> m);
      lw    = 256 / nl;
      n     = 0;
      found = 1'b0;
      for (int i = 0; i < nl; i++) begin
         t = c >> ((i + 1) * lw - 1);
         e.mask = e.mask | (32'(t[0]) << i);
         if (t[0]) begin
            n++;
            if (!found) begin
               e.first = 5'(i);
               found   = 1'b1;
            end
         end
      end
      e.cnt  = 6'(n);
      e.any  = (n != 0);
      e.all  = (n == nl);
      e.mode = m;
      return e;
   endfunction

   function automatic exp_t observed();
      exp_t o;
      o.mask  = lane_mask;
      o.cnt   = lane_count;
      o.any   = any_set;
      o.all   = all_set;
      o.first = first_idx;
      o.mode  = out_mode;
      return o;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic fail_now(input string tag);
      vectors++;
      miscompares++;
      $error("FAIL %s observed=timeout expected=progress", tag);
   endtask

   // One clock: check held output, pop on output transfer, push on input transfer
   task automatic tick();
      exp_t o;
      #1;
      o = observed();
      if (held_valid) begin
         chk("hold_valid", 64'(out_valid), 64'd1);
         chk("hold_data", 64'(o), 64'(held));
      end
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL unexpected_output observed=%0h expected=none", o);
         end else begin
            chk("result", 64'(o), 64'(sb.pop_front()));
         end
         popped++;
      end
      held_valid = out_valid && !out_ready;
      held       = o;
      if (in_valid && in_ready) begin
         sb.push_back(model(cmp_in, data_mode));
         accepted++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_accept(input string tag);
      int a0;
      int b;
      a0 = accepted;
      b  = 0;
      while (accepted == a0 && b < 50) begin
         tick();
         b++;
      end
      if (accepted == a0) fail_now(tag);
   endtask

   task automatic drain(input string tag);
      int b;
      b = 0;
      while ((sb.size() != 0 || out_valid) && b < 200) begin
         tick();
         b++;
      end
      if (sb.size() != 0 || out_valid) fail_now(tag);
   endtask

   // Single transaction with latency and field checks
   task automatic directed(input string tag, input logic [255:0] c, input logic [2:0] m,
                           input logic [31:0] emask, input logic [5:0] ecnt, input logic eany,
                           input logic eall, input logic [4:0] efirst);
      cmp_in    = c;
      data_mode = m;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
      tick();
      chk({tag, "_lat2"}, 64'(out_valid), 64'd1);
      chk({tag, "_mask"}, 64'(lane_mask), 64'(emask));
      chk({tag, "_cnt"}, 64'(lane_count), 64'(ecnt));
      chk({tag, "_any"}, 64'(any_set), 64'(eany));
      chk({tag, "_all"}, 64'(all_set), 64'(eall));
      chk({tag, "_first"}, 64'(first_idx), 64'(efirst));
      chk({tag, "_mode"}, 64'(out_mode), 64'(m));
      drain({tag, "_drain"});
   endtask

   function automatic logic [255:0] rand_vec();
      logic [255:0] v;
      int           sel;
      for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) v = '1;
      else if (sel == 1) v = '0;
      return v;
   endfunction

   initial begin
      logic [255:0] pat;
      int           p0;
      int           cyc;
      bit           pending;

      rst       = 1'b1;
      in_valid  = 1'b0;
      cmp_in    = '0;
      data_mode = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_mask", 64'(lane_mask), 64'd0);
      chk("rst_cnt", 64'(lane_count), 64'd0);
      chk("rst_any", 64'(any_set), 64'd0);
      chk("rst_all", 64'(all_set), 64'd0);
      chk("rst_first", 64'(first_idx), 64'd0);
      chk("rst_mode", 64'(out_mode), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);

      pat = {16{16'h00FF}};
      directed("m0_alt", pat, 3'd0, 32'h5555_5555, 6'd16, 1'b1, 1'b0, 5'd0);
      pat = 256'(32'hFFFF_FFFF) << 96;
      directed("m2_lane3", pat, 3'd2, 32'h0000_0008, 6'd1, 1'b1, 1'b0, 5'd3);
      pat = '1;
      directed("m4_ones", pat, 3'd4, 32'h0000_0003, 6'd2, 1'b1, 1'b1, 5'd0);
      pat = '0;
      directed("m6_zero", pat, 3'd6, 32'h0000_0000, 6'd0, 1'b0, 1'b0, 5'd0);
      pat = 256'(1) << 255;
      directed("m7_top", pat, 3'd7, 32'h0000_0001, 6'd1, 1'b1, 1'b1, 5'd0);
      pat = 256'(8'h80) << 248;
      directed("m0_lane31", pat, 3'd0, 32'h8000_0000, 6'd1, 1'b1, 1'b0, 5'd31);

      // Backpressure: four inputs with the consumer stalled
      out_ready = 1'b0;
      p0        = popped;
      for (int k = 0; k < 4; k++) begin
         cmp_in    = rand_vec();
         data_mode = 3'(k);
         in_valid  = 1'b1;
         wait_accept("bp_accept");
         if (k == 1) begin
            for (int s = 0; s < 3; s++) begin
               #1;
               chk("bp_in_ready_low", 64'(in_ready), 64'd0);
               chk("bp_out_valid", 64'(out_valid), 64'd1);
               tick();
            end
            out_ready = 1'b1;
         end
      end
      in_valid = 1'b0;
      drain("bp_drain");
      chk("bp_pop_count", 64'(popped - p0), 64'd4);

      // Asynchronous reset with two entries in flight
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cmp_in    = '1;
         data_mode = 3'd3;
         in_valid  = 1'b1;
         wait_accept("ar_accept");
      end
      in_valid = 1'b0;
      #1;
      chk("ar_full", 64'(out_valid), 64'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("ar_out_valid", 64'(out_valid), 64'd0);
      chk("ar_mask", 64'(lane_mask), 64'd0);
      chk("ar_cnt", 64'(lane_count), 64'd0);
      chk("ar_mode", 64'(out_mode), 64'd0);
      chk("ar_in_ready", 64'(in_ready), 64'd1);
      sb.delete();
      held_valid = 1'b0;
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);

      // Randomised valid/ready traffic
      p0      = popped;
      cyc     = 0;
      pending = 1'b0;
      begin
         int a0;
         a0 = accepted;
         while (accepted - a0 < 1000 && cyc < 20000) begin
            if (!pending) begin
               in_valid  = ($urandom_range(0, 3) != 0);
               cmp_in    = rand_vec();
               data_mode = 3'($urandom_range(0, 7));
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            pending = in_valid && !in_ready;
            tick();
            cyc++;
         end
         if (accepted - a0 < 1000) fail_now("rand_accept");
         in_valid  = 1'b0;
         out_ready = 1'b1;
         drain("rand_drain");
         chk("rand_pop_count", 64'(popped - p0), 64'(accepted - a0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
